pipelined_adder_n: RTL and testbench

PIPELINED_ADDER_N -- requirements
Module: pipelined_adder_n

---
 rtl/pipelined_adder_n.sv | 125 ++++++++++++
 tb/tb_pipelined_adder_n.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_n.sv
// STAGES-deep pipelined adder/subtractor with valid/ready handshake; each stage ripples WIDTH/STAGES bits.
// Latency STAGES cycles; the whole pipe freezes while the last slot holds a result not taken downstream.
module pipelined_adder_n #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int C = WIDTH / STAGES;

   if (WIDTH < 4 || WIDTH > 64 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_adder_n: WIDTH must be 4..64 and a multiple of STAGES");
   end

   logic             vld_q  [STAGES];
   logic             vld_d  [STAGES];
   logic [WIDTH-1:0] opa_q  [STAGES];
   logic [WIDTH-1:0] opa_d  [STAGES];
   logic [WIDTH-1:0] opb_q  [STAGES];
   logic [WIDTH-1:0] opb_d  [STAGES];
   logic [WIDTH-1:0] acc_q  [STAGES];
   logic [WIDTH-1:0] acc_d  [STAGES];
   logic             cy_q   [STAGES];
   logic             cy_d   [STAGES];
   logic             amsb_q [STAGES];
   logic             amsb_d [STAGES];
   logic             bmsb_q [STAGES];
   logic             bmsb_d [STAGES];
   logic             ovf_q;
   logic             ovf_d;
   logic             adv;

   assign adv      = !vld_q[STAGES-1] || out_ready;
   assign in_ready = adv && !rst;

   // Operands shift right by one chunk per stage so the live chunk is always at [C-1:0];
   // finished sum chunks enter at the top and slide down into place.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             src_v;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_s;
      logic             src_c;
      logic             src_am;
      logic             src_bm;
      logic [C:0]       part;

      if (k == 0) begin : g_head
         assign src_v  = in_valid && in_ready;
         assign src_a  = a;
         assign src_b  = sub ? ~b : b;
         assign src_s  = '0;
         assign src_c  = sub | cin;
         assign src_am = a[WIDTH-1];
         assign src_bm = src_b[WIDTH-1];
      end else begin : g_body
         assign src_v  = vld_q[k-1];
         assign src_a  = opa_q[k-1];
         assign src_b  = opb_q[k-1];
         assign src_s  = acc_q[k-1];
         assign src_c  = cy_q[k-1];
         assign src_am = amsb_q[k-1];
         assign src_bm = bmsb_q[k-1];
      end

      assign part = {1'b0, src_a[C-1:0]} + {1'b0, src_b[C-1:0]} + {{C{1'b0}}, src_c};

      // Invalid slots carry all-zero data so the output reads 0 without extra gating.
      assign vld_d[k]  = src_v;
      assign opa_d[k]  = src_v ? (src_a >> C) : '0;
      assign opb_d[k]  = src_v ? (src_b >> C) : '0;
      assign acc_d[k]  = src_v ? WIDTH'({part[C-1:0], src_s} >> C) : '0;
      assign cy_d[k]   = src_v && part[C];
      assign amsb_d[k] = src_v && src_am;
      assign bmsb_d[k] = src_v && src_bm;

      if (k == STAGES - 1) begin : g_tail
         // b is already inverted for subtract, so one equal-signs rule covers both modes.
         assign ovf_d = src_v && (src_am == src_bm) && (part[C-1] != src_am);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k]  <= 1'b0;
            opa_q[k]  <= '0;
            opb_q[k]  <= '0;
            acc_q[k]  <= '0;
            cy_q[k]   <= 1'b0;
            amsb_q[k] <= 1'b0;
            bmsb_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         vld_q  <= vld_d;
         opa_q  <= opa_d;
         opb_q  <= opb_d;
         acc_q  <= acc_d;
         cy_q   <= cy_d;
         amsb_q <= amsb_d;
         bmsb_q <= bmsb_d;
         ovf_q  <= ovf_d;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign sum       = acc_q[STAGES-1];
   assign cout      = cy_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Directed checks on an 8-bit/2-stage adder plus a randomised scoreboard run on a 16-bit/4-stage one.
module tb_pipelined_adder_n;

   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [7:0]  a, b, sum;

   logic        v16, r16, cin16, sub16, ov16, ordy16, cout16, ovf16;
   logic [15:0] a16, b16, sum16;

   always #5 clk = ~clk;

   pipelined_adder_n #(.WIDTH(8), .STAGES(2)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipelined_adder_n #(.WIDTH(16), .STAGES(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
      .a(a16), .b(b16), .cin(cin16), .sub(sub16),
      .out_valid(ov16), .out_ready(ordy16),
      .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic sv, input logic vv);
      a = av; b = bv; cin = cv; sub = sv; in_valid = vv;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      drive(8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 0", i, in_ready);
         end
      end
      n_cmp++;
      if (r16 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready16: got %b want 0", r16); end
      rst = 1'b0;
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if ({out_valid, sum, cout, ovf} !== 11'd0) begin
         n_bad++; $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b want all 0", out_valid, sum, cout, ovf);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      n_cmp++;
      if (ov16 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid16: got %b want 0", ov16); end
      tick();
   endtask

   task automatic test_arith(input bit do_sub);
      logic [7:0] va[4], vb[4], es[4];
      logic       vc[4], ec[4], eo[4];
      int         n;
      if (!do_sub) begin
         n = 3;
         va = '{8'h0D, 8'hFF, 8'h7F, 8'h00}; vb = '{8'h05, 8'hFF, 8'h01, 8'h00};
         vc = '{1'b0, 1'b1, 1'b0, 1'b0};
         es = '{8'h12, 8'hFF, 8'h80, 8'h00}; ec = '{1'b0, 1'b1, 1'b0, 1'b0};
         eo = '{1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
         n = 4;
         va = '{8'h05, 8'h80, 8'h50, 8'h05}; vb = '{8'h0A, 8'h01, 8'h50, 8'h0A};
         vc = '{1'b0, 1'b0, 1'b0, 1'b1};
         es = '{8'hFB, 8'h7F, 8'h00, 8'hFB}; ec = '{1'b0, 1'b1, 1'b1, 1'b0};
         eo = '{1'b0, 1'b1, 1'b0, 1'b0};
      end
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         drive(va[i], vb[i], vc[i], do_sub, 1'b1);
         tick();
         drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL arith%0d[%0d]_early: out_valid got %b want 0", do_sub, i, out_valid);
         end
         tick();
         n_cmp++;
         if ({out_valid, sum, cout, ovf} !== {1'b1, es[i], ec[i], eo[i]}) begin
            n_bad++;
            $display("FAIL arith%0d[%0d]: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b",
                     do_sub, i, out_valid, sum, cout, ovf, es[i], ec[i], eo[i]);
         end
         tick();
         n_cmp++;
         if ({out_valid, sum, cout, ovf} !== 11'd0) begin
            n_bad++; $display("FAIL arith%0d[%0d]_drain: got v=%b s=%h c=%b o=%b want all 0",
                              do_sub, i, out_valid, sum, cout, ovf);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] va[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
      logic [7:0] vb[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      logic [7:0] es[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] exp_q[$];
      int idx = 0;
      int got = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         out_ready = !(cyc >= 2 && cyc < 5);
         if (idx < 4) drive(va[idx], vb[idx], 1'b0, 1'b0, 1'b1);
         else         drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
         #1;
         if (!out_ready) begin
            n_cmp++;
            if ({in_ready, out_valid, sum, cout} !== {2'b01, exp_q[0], 1'b0}) begin
               n_bad++; $display("FAIL stall[%0d]: got rdy=%b v=%b s=%h c=%b want rdy=0 v=1 s=%h c=0",
                                 cyc, in_ready, out_valid, sum, cout, exp_q[0]);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0 || sum !== exp_q[0]) begin
               n_bad++; $display("FAIL b2b_order[%0d]: got s=%h want %h", got, sum,
                                 (exp_q.size() == 0) ? 8'hXX : exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(es[idx]);
            idx++;
         end
         tick();
      end
      n_cmp++;
      if (got != 4 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL b2b_count: got %0d results want 4", got);
      end
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
      tick();
      drive(8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      drive(8'h33, 8'h33, 1'b1, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
      tick();
      rst = 1'b0;
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++; $display("FAIL midrst_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_ghost[%0d]: out_valid got %b want 0", i, out_valid);
         end
      end
      drive(8'h21, 8'h03, 1'b0, 1'b0, 1'b1);
      tick();
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_new_early: got %b want 0", out_valid); end
      tick();
      n_cmp++;
      if ({out_valid, sum} !== {1'b1, 8'h24}) begin
         n_bad++; $display("FAIL midrst_new: got v=%b s=%h want v=1 s=24", out_valid, sum);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_single: got %b want 0", out_valid); end
   endtask

   task automatic test_random16();
      logic [17:0] exp_q[$];
      int          acc_q[$];
      logic [16:0] t;
      logic        o;
      logic [17:0] e;
      int          acc;
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      int last_stall = -1;
      while ((sent < 1000 || recv < sent) && cyc < 20000) begin
         if (sent < 1000 && $urandom_range(0, 3) != 0) begin
            v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom); sub16 = 1'($urandom);
         end else begin
            v16 = 1'b0;
         end
         ordy16 = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
         #1;
         if (ov16 && !ordy16) last_stall = cyc;
         if (ov16 && ordy16) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL rnd_extra: unexpected result s=%h at cycle %0d", sum16, cyc);
            end else begin
               e = exp_q.pop_front();
               acc = acc_q.pop_front();
               if ({ovf16, cout16, sum16} !== e) begin
                  n_bad++; $display("FAIL rnd_data[%0d]: got o=%b c=%b s=%h want o=%b c=%b s=%h",
                                    recv, ovf16, cout16, sum16, e[17], e[16], e[15:0]);
               end
               if (last_stall < acc) begin
                  n_cmp++;
                  if (cyc - acc != 4) begin
                     n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 4", recv, cyc - acc);
                  end
               end
            end
            recv++;
         end else if (!ov16) begin
            n_cmp++;
            if ({sum16, cout16, ovf16} !== 18'd0) begin
               n_bad++; $display("FAIL rnd_idle_zero: got s=%h c=%b o=%b want 0", sum16, cout16, ovf16);
            end
         end
         if (v16 && r16) begin
            if (sub16) t = {1'b0, a16} + {1'b0, ~b16} + 17'd1;
            else       t = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
            if (sub16) o = (a16[15] != b16[15]) && (t[15] != a16[15]);
            else       o = (a16[15] == b16[15]) && (t[15] != a16[15]);
            exp_q.push_back({o, t});
            acc_q.push_back(cyc);
            sent++;
         end
         tick();
         cyc++;
      end
      v16 = 1'b0;
      n_cmp++;
      if (recv != 1000 || cyc >= 20000) begin
         n_bad++; $display("FAIL rnd_count: got %0d results in %0d cycles want 1000", recv, cyc);
      end
   endtask

   initial begin
      v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
      test_reset();
      test_arith(1'b0);
      test_arith(1'b1);
      test_back_to_back();
      test_reset_midflight();
      test_random16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
